tile_skew_feeder: RTL

//  Feeds the 4x4 systolic ArrangeArray from the tile fetch logic. Accepts one A tile and one B tile
//  (row-major, packed) per valid/ready handshake and streams them as diagonally skewed row/column wavefronts.

---
 rtl/tile_skew_feeder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tile_skew_feeder.sv
// rtl/tile_skew_feeder.sv - skews A/B tiles into diagonal wavefronts for a 4x4 systolic array
module tile_skew_feeder #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                   clk,
    input  logic                   _reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*N*WIDTH-1:0]   tile_a,
    input  logic [N*N*WIDTH-1:0]   tile_b,
    input  logic                   last_tile_in,
    input  logic                   end_row_in,
    input  logic                   end_head_in,
    input  logic                   stall,
    output logic [N*WIDTH-1:0]     a_row,
    output logic [N*WIDTH-1:0]     b_col,
    output logic [2*N-1:0]         enables,
    output logic                   add_flag,
    output logic                   last_tile,
    output logic                   end_of_row,
    output logic                   end_of_head,
    output logic                   busy
);
    localparam int KW = $clog2(2*N-1);
    localparam logic [KW-1:0] K_LAST = KW'(2*N-2);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]            state;
    logic [KW-1:0]         k;
    logic                  skid_full;
    logic                  group_open;
    logic [N*N*WIDTH-1:0]  skid_a, skid_b, act_a, act_b;
    logic                  skid_last, skid_row, skid_head;
    logic                  act_last, act_row, act_head, act_add;
    logic [N*WIDTH-1:0]    wave_a, wave_b;
    logic [2*N-1:0]        wave_en;
    logic                  tile_done, drain, accept;

    assign in_ready  = !skid_full;
    assign busy      = (state == ST_STREAM) || skid_full;
    assign accept    = in_valid && !skid_full;
    assign tile_done = (state == ST_STREAM) && (k == K_LAST);
    // Skid drains either into an idle array or onto the final wavefront of the current tile.
    assign drain     = !stall && skid_full && ((state == ST_IDLE) || tile_done);

    always_comb begin
        wave_a  = '0;
        wave_b  = '0;
        wave_en = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(k) >= i && int'(k) - i < N) begin
                wave_a[i*WIDTH +: WIDTH] = act_a[(i*N + int'(k) - i)*WIDTH +: WIDTH];
                wave_b[i*WIDTH +: WIDTH] = act_b[((int'(k) - i)*N + i)*WIDTH +: WIDTH];
                wave_en[i]               = 1'b1;
                wave_en[N+i]             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            skid_a    <= tile_a;
            skid_b    <= tile_b;
            skid_last <= last_tile_in;
            skid_row  <= end_row_in;
            skid_head <= end_head_in;
        end
        if (drain) begin
            act_a    <= skid_a;
            act_b    <= skid_b;
            act_last <= skid_last;
            act_row  <= skid_row;
            act_head <= skid_head;
            act_add  <= group_open && !(tile_done && act_last);
        end
    end

    always_ff @(posedge clk) begin
        if (_reset) begin
            state       <= ST_IDLE;
            k           <= '0;
            skid_full   <= 1'b0;
            group_open  <= 1'b0;
            a_row       <= '0;
            b_col       <= '0;
            enables     <= '0;
            add_flag    <= 1'b0;
            last_tile   <= 1'b0;
            end_of_row  <= 1'b0;
            end_of_head <= 1'b0;
        end else begin
            if (accept) begin
                skid_full <= 1'b1;
            end else if (drain) begin
                skid_full <= 1'b0;
            end

            if (drain) begin
                state      <= ST_STREAM;
                k          <= '0;
                group_open <= 1'b1;
            end else if (!stall && tile_done) begin
                state <= ST_IDLE;
                k     <= '0;
                if (act_last) begin
                    group_open <= 1'b0;
                end
            end else if (!stall && state == ST_STREAM) begin
                k <= k + KW'(1);
            end

            if (!stall) begin
                if (state == ST_STREAM) begin
                    a_row       <= wave_a;
                    b_col       <= wave_b;
                    enables     <= wave_en;
                    add_flag    <= act_add;
                    last_tile   <= tile_done && act_last;
                    end_of_row  <= tile_done && act_row;
                    end_of_head <= tile_done && act_head;
                end else begin
                    a_row       <= '0;
                    b_col       <= '0;
                    enables     <= '0;
                    add_flag    <= 1'b0;
                    last_tile   <= 1'b0;
                    end_of_row  <= 1'b0;
                    end_of_head <= 1'b0;
                end
            end
        end
    end
endmodule
